// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- fetch/data request ports and shared-memory bus of mem_port_arbiter.
// master = arbiter view, slave = requesters plus memory view. Rev 1.0.
`default_nettype none

interface mem_port_arbiter_if;
  logic        IReqF;
  logic [31:0] IAddrF;
  logic        DReqM;
  logic        DWrM;
  logic [31:0] DAddrM;
  logic [31:0] DWDataM;
  logic        MemRdy;
  logic [31:0] MemRData;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] IRData;
  logic        IValid;
  logic [31:0] DRData;
  logic        DValid;
  logic        StallFetch;
  logic        StallMem;

  modport master (
    input  IReqF, IAddrF, DReqM, DWrM, DAddrM, DWDataM, MemRdy, MemRData,
    output MemReq, MemWe, MemAddr, MemWData, IRData, IValid, DRData, DValid,
    output StallFetch, StallMem
  );

  modport slave (
    output IReqF, IAddrF, DReqM, DWrM, DAddrM, DWDataM, MemRdy, MemRData,
    input  MemReq, MemWe, MemAddr, MemWData, IRData, IValid, DRData, DValid,
    input  StallFetch, StallMem
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one memory port between fetch and data, one access in flight.
// Optional ARB_RR_EN: round-robin on contention instead of fixed data priority. Rev 1.0.
`default_nettype none

module mem_port_arbiter (
  input  wire logic          clk,
  input  wire logic          reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        mem_req, mem_req_nxt;
  logic        mem_we, mem_we_nxt;
  logic [31:0] mem_addr, mem_addr_nxt;
  logic [31:0] mem_wdata, mem_wdata_nxt;
  logic [31:0] irdata, irdata_nxt;
  logic [31:0] drdata, drdata_nxt;
  logic        ivalid, ivalid_nxt;
  logic        dvalid, dvalid_nxt;
  logic        grant_data;

`ifdef ARB_RR_EN
  logic last_data, last_data_nxt;

  // Under contention the side not served last wins; a lone requester always wins.
  always_comb grant_data = bus.DReqM && (!bus.IReqF || !last_data);
`else
  // Data wins contention: it belongs to an older instruction than the fetch.
  always_comb grant_data = bus.DReqM;
`endif

  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = 1'b0;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    irdata_nxt    = irdata;
    drdata_nxt    = drdata;
    ivalid_nxt    = 1'b0;
    dvalid_nxt    = 1'b0;
`ifdef ARB_RR_EN
    last_data_nxt = last_data;
`endif
    case (state)
      IDLE: begin
        // Skip the completion cycle so the served requester can drop its request.
        if (!ivalid && !dvalid && (bus.IReqF || bus.DReqM)) begin
          mem_req_nxt = 1'b1;
          if (grant_data) begin
            state_nxt     = D_WAIT;
            mem_we_nxt    = bus.DWrM;
            mem_addr_nxt  = bus.DAddrM;
            mem_wdata_nxt = bus.DWDataM;
`ifdef ARB_RR_EN
            last_data_nxt = 1'b1;
`endif
          end else begin
            state_nxt     = I_WAIT;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = bus.IAddrF;
            mem_wdata_nxt = 32'd0;
`ifdef ARB_RR_EN
            last_data_nxt = 1'b0;
`endif
          end
        end
      end
      I_WAIT: begin
        if (bus.MemRdy) begin
          irdata_nxt = bus.MemRData;
          ivalid_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      D_WAIT: begin
        if (bus.MemRdy) begin
          if (!mem_we) drdata_nxt = bus.MemRData;
          dvalid_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      irdata    <= 32'd0;
      drdata    <= 32'd0;
      ivalid    <= 1'b0;
      dvalid    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      irdata    <= irdata_nxt;
      drdata    <= drdata_nxt;
      ivalid    <= ivalid_nxt;
      dvalid    <= dvalid_nxt;
    end
  end

`ifdef ARB_RR_EN
  // Reset to fetch-last so the first contended grant goes to data.
  always_ff @(posedge clk) begin
    if (reset) last_data <= 1'b0;
    else       last_data <= last_data_nxt;
  end
`endif

  assign bus.MemReq     = mem_req;
  assign bus.MemWe      = mem_we;
  assign bus.MemAddr    = mem_addr;
  assign bus.MemWData   = mem_wdata;
  assign bus.IRData     = irdata;
  assign bus.IValid     = ivalid;
  assign bus.DRData     = drdata;
  assign bus.DValid     = dvalid;
  assign bus.StallFetch = bus.IReqF & ~ivalid;
  assign bus.StallMem   = bus.DReqM & ~dvalid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- directed scenarios plus random traffic against a transaction-level model.
// Honours ARB_RR_EN the same way as the design. Rev 1.0.
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding access, completion seen the cycle after MemRdy.
  bit          m_live = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_owner_d = 1'b0;
  bit          m_last_d = 1'b0;
  logic        e_memreq = 1'b0, e_memwe = 1'b0, e_ivalid = 1'b0, e_dvalid = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_irdata = 32'd0, e_drdata = 32'd0;

  // Memory responder controls
  int          mem_cnt = 0;
  int          dly_min = 1, dly_max = 3;
  bit          use_fixed = 1'b0, spurious_en = 1'b0;
  logic [31:0] fixed_data = 32'd0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_cycle();
    bit valid_now, pick_d;
    valid_now = e_ivalid || e_dvalid;
    e_memreq = 1'b0; e_ivalid = 1'b0; e_dvalid = 1'b0;
    if (reset) begin
      m_live = 1'b1; m_busy = 1'b0; m_last_d = 1'b0;
      e_memwe = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_irdata = 32'd0; e_drdata = 32'd0;
    end else if (m_busy) begin
      if (bus.MemRdy) begin
        m_busy = 1'b0;
        if (m_owner_d) begin
          e_dvalid = 1'b1;
          if (!e_memwe) e_drdata = bus.MemRData;
        end else begin
          e_ivalid = 1'b1;
          e_irdata = bus.MemRData;
        end
      end
    end else if (!valid_now && (bus.IReqF || bus.DReqM)) begin
`ifdef ARB_RR_EN
      pick_d = bus.DReqM && !(bus.IReqF && m_last_d);
`else
      pick_d = bus.DReqM;
`endif
      m_busy = 1'b1; m_owner_d = pick_d; m_last_d = pick_d; e_memreq = 1'b1;
      if (pick_d) begin
        e_memwe = bus.DWrM; e_addr = bus.DAddrM; e_wdata = bus.DWDataM;
      end else begin
        e_memwe = 1'b0; e_addr = bus.IAddrF;
      end
    end
  endtask

  // Checks combinational stalls, advances the model, crosses one clock edge, checks registered outputs.
  task automatic step();
    #1;
    if (m_live) begin
      check_value("stall_fetch", 32'(bus.StallFetch), 32'(bus.IReqF & ~e_ivalid));
      check_value("stall_mem", 32'(bus.StallMem), 32'(bus.DReqM & ~e_dvalid));
    end
    model_cycle();
    @(posedge clk);
    #1;
    if (m_live) begin
      check_value("mem_req", 32'(bus.MemReq), 32'(e_memreq));
      check_value("ivalid", 32'(bus.IValid), 32'(e_ivalid));
      check_value("dvalid", 32'(bus.DValid), 32'(e_dvalid));
      check_value("mem_we", 32'(bus.MemWe), 32'(e_memwe));
      check_value("mem_addr", bus.MemAddr, e_addr);
      if (e_memwe) check_value("mem_wdata", bus.MemWData, e_wdata);
      check_value("irdata", bus.IRData, e_irdata);
      check_value("drdata", bus.DRData, e_drdata);
    end
  endtask

  task automatic mem_respond();
    bus.MemRdy   = 1'b0;
    bus.MemRData = use_fixed ? fixed_data : $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) bus.MemRdy = 1'b1;
    end else if (bus.MemReq) begin
      mem_cnt = int'($urandom_range(dly_max, dly_min));
    end else if (spurious_en && $urandom_range(7, 0) == 0) begin
      bus.MemRdy = 1'b1;
    end
  endtask

  task automatic drive_requesters();
    if (bus.IReqF) begin
      if (bus.IValid) begin
        bus.IReqF  = ($urandom_range(1, 0) == 1);
        bus.IAddrF = $urandom;
      end
    end else if ($urandom_range(2, 0) == 0) begin
      bus.IReqF  = 1'b1;
      bus.IAddrF = $urandom;
    end
    if (bus.DReqM) begin
      if (bus.DValid) begin
        bus.DReqM   = ($urandom_range(1, 0) == 1);
        bus.DWrM    = ($urandom_range(1, 0) == 1);
        bus.DAddrM  = $urandom;
        bus.DWDataM = $urandom;
      end
    end else if ($urandom_range(2, 0) == 0) begin
      bus.DReqM   = 1'b1;
      bus.DWrM    = ($urandom_range(1, 0) == 1);
      bus.DAddrM  = $urandom;
      bus.DWDataM = $urandom;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.IReqF = 1'b0; bus.DReqM = 1'b0; bus.MemRdy = 1'b0;
    mem_cnt = 0;
    step();
    step();
    reset = 1'b0;
    check_value("rst_mem_req", 32'(bus.MemReq), 32'd0);
    check_value("rst_mem_we", 32'(bus.MemWe), 32'd0);
    check_value("rst_mem_addr", bus.MemAddr, 32'd0);
    check_value("rst_mem_wdata", bus.MemWData, 32'd0);
    check_value("rst_valids", 32'({bus.IValid, bus.DValid}), 32'd0);
    check_value("rst_rdata", bus.IRData | bus.DRData, 32'd0);
  endtask

  initial begin
    int n_req, n_val, dcount, ng;
    logic [3:0] seq;

    reset = 1'b1;
    bus.IReqF = 1'b0; bus.IAddrF = 32'd0;
    bus.DReqM = 1'b0; bus.DWrM = 1'b0; bus.DAddrM = 32'd0; bus.DWDataM = 32'd0;
    bus.MemRdy = 1'b0; bus.MemRData = 32'd0;

    // Lone fetch, memory answers two cycles after MemReq
    do_reset();
    use_fixed = 1'b1; fixed_data = 32'hE3A00001; dly_min = 2; dly_max = 2; spurious_en = 1'b0;
    bus.IReqF = 1'b1; bus.IAddrF = 32'h100;
    n_req = 0; n_val = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.MemReq) begin
        n_req++;
        check_value("fetch_addr", bus.MemAddr, 32'h100);
        check_value("fetch_we", 32'(bus.MemWe), 32'd0);
      end
      if (bus.IValid) begin
        n_val++;
        check_value("fetch_data", bus.IRData, 32'hE3A00001);
        bus.IReqF = 1'b0;
      end
      mem_respond();
    end
    check_value("fetch_req_count", 32'(n_req), 32'd1);
    check_value("fetch_valid_count", 32'(n_val), 32'd1);

    // Store leaves DRData untouched even though MemRData is non-zero
    fixed_data = 32'h12345678;
    bus.DReqM = 1'b1; bus.DWrM = 1'b1; bus.DAddrM = 32'h2000; bus.DWDataM = 32'hDEADBEEF;
    n_req = 0; n_val = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.MemReq) begin
        n_req++;
        check_value("store_we", 32'(bus.MemWe), 32'd1);
        check_value("store_addr", bus.MemAddr, 32'h2000);
        check_value("store_wdata", bus.MemWData, 32'hDEADBEEF);
      end
      if (bus.DValid) begin
        n_val++;
        check_value("store_drdata", bus.DRData, 32'd0);
        bus.DReqM = 1'b0;
      end
      mem_respond();
    end
    check_value("store_req_count", 32'(n_req), 32'd1);
    check_value("store_valid_count", 32'(n_val), 32'd1);

    // Contention: both requesters held; data drops after its third completion
    do_reset();
    use_fixed = 1'b0; dly_min = 1; dly_max = 1;
    bus.IReqF = 1'b1; bus.IAddrF = 32'h40;
    bus.DReqM = 1'b1; bus.DWrM = 1'b0; bus.DAddrM = 32'h80;
    seq = 4'd0; ng = 0; dcount = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      step();
      if (bus.MemReq) begin
        seq = {seq[2:0], bus.MemAddr == 32'h80};
        ng++;
      end
      if (bus.DValid) begin
        dcount++;
        if (dcount == 3) bus.DReqM = 1'b0;
      end
      mem_respond();
    end
    check_value("contention_grants", 32'(ng), 32'd4);
`ifdef ARB_RR_EN
    check_value("contention_order", 32'(seq), 32'(4'b1010));
`else
    check_value("contention_order", 32'(seq), 32'(4'b1110));
`endif

    // Reset while a load is outstanding, then a late MemRdy
    do_reset();
    bus.IReqF = 1'b0;
    bus.DReqM = 1'b1; bus.DWrM = 1'b0; bus.DAddrM = 32'h300;
    n_req = 0;
    for (int c = 0; c < 10 && n_req == 0; c++) begin
      step();
      if (bus.MemReq) n_req++;
    end
    check_value("midflight_issued", 32'(n_req), 32'd1);
    step();
    reset = 1'b1; bus.DReqM = 1'b0;
    step();
    reset = 1'b0;
    step();
    bus.MemRdy = 1'b1; bus.MemRData = 32'hCAFEF00D;
    step();
    bus.MemRdy = 1'b0;
    step();
    check_value("midflight_dvalid", 32'(bus.DValid), 32'd0);
    check_value("midflight_ctl", 32'({bus.MemReq, bus.MemWe, bus.IValid}), 32'd0);
    check_value("midflight_data", bus.MemAddr | bus.MemWData | bus.IRData | bus.DRData, 32'd0);

    // Spurious MemRdy with nobody requesting
    n_req = 0; n_val = 0;
    for (int c = 0; c < 12; c++) begin
      bus.MemRdy = c[0];
      bus.MemRData = $urandom;
      step();
      if (bus.MemReq) n_req++;
      if (bus.IValid || bus.DValid) n_val++;
    end
    bus.MemRdy = 1'b0;
    check_value("spurious_req", 32'(n_req), 32'd0);
    check_value("spurious_valid", 32'(n_val), 32'd0);

    // Random traffic with variable latency and spurious MemRdy pulses
    do_reset();
    dly_min = 1; dly_max = 3; spurious_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      drive_requesters();
      mem_respond();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
